// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the sequence generator: FSM state encoding,
// per-character decode and the compile-time sequence length scan.
package seq_gen_pkg;

  localparam int unsigned MaxLen  = 128;
  localparam int unsigned SeqBits = 8 * MaxLen;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] val;
    logic       dc;
  } dec_t;

  // Map one ASCII character to a nibble; anything unrecognised is a don't-care.
  function automatic dec_t dec_char(input logic [7:0] c);
    dec_t d;
    d.val = 4'h0;
    d.dc  = 1'b1;
    if (c >= 8'h30 && c <= 8'h39) begin        // '0'..'9'
      d.val = 4'(c - 8'h30);
      d.dc  = 1'b0;
    end else if (c >= 8'h41 && c <= 8'h46) begin // 'A'..'F'
      d.val = 4'(c - 8'h37);
      d.dc  = 1'b0;
    end else if (c >= 8'h61 && c <= 8'h66) begin // 'a'..'f'
      d.val = 4'(c - 8'h57);
      d.dc  = 1'b0;
    end else if (c == 8'h5f) begin               // '_'
      d.val = 4'h0;
      d.dc  = 1'b0;
    end else if (c == 8'h2d) begin               // '-'
      d.val = 4'hf;
      d.dc  = 1'b0;
    end
    return d;
  endfunction

  // Strings are right-justified, so the length is the position of the highest nonzero byte.
  function automatic int unsigned seq_len(input logic [SeqBits-1:0] s);
    int unsigned len;
    len = 0;
    for (int unsigned i = 0; i < MaxLen; i++) begin
      if (s[i*8 +: 8] != 8'h00) len = i + 1;
    end
    return len;
  endfunction

endpackage

// File: rtl/seq_char_dec.sv
// Decodes one sequence character into a 4-bit value and a don't-care flag.
module seq_char_dec
  import seq_gen_pkg::*;
(
  input  logic [7:0] ch,
  output logic [3:0] val,
  output logic       dc
);

  dec_t d;

  // Pure lookup; no state.
  always_comb begin
    d   = dec_char(ch);
    val = d.val;
    dc  = d.dc;
  end

endmodule

// File: rtl/seq_gen.sv
// Plays a compile-time character string out as parallel per-channel step data.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter logic [SeqBits-1:0] SEQ  = '0,
  parameter int unsigned        N    = 1,
  parameter int unsigned        CH   = 1,
  parameter int unsigned        LOOP = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  output logic [CH*N-1:0] dout,
  output logic [CH-1:0]   dc,
  output logic            valid,
  output logic            done,
  output logic [7:0]      step
);

  localparam int unsigned Len      = seq_len(SEQ);
  localparam int unsigned Steps    = Len / CH;
  localparam logic [7:0]  LastStep = 8'(Steps - 1);

  if (Len == 0 || (Len % CH) != 0) begin : g_bad_seq
    $error("seq_gen: SEQ length must be nonzero and a multiple of CH");
  end
  if (N < 1 || N > 4) begin : g_bad_n
    $error("seq_gen: N must be in 1..4");
  end
  if (CH < 1 || CH > 4) begin : g_bad_ch
    $error("seq_gen: CH must be in 1..4");
  end

  state_e     state_q, state_d;
  logic [7:0] step_q, step_d;

  // State and step registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      step_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Next-state: start launches from IDLE/DONE, stall only matters in RUN.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          step_d  = 8'd0;
        end
      end
      StRun: begin
        if (!stall) begin
          if (step_q < LastStep) begin
            step_d = step_q + 8'd1;
          end else if (LOOP != 0) begin
            step_d = 8'd0;
          end else begin
            state_d = StDone;
          end
        end
      end
      default: begin
        state_d = StIdle;
        step_d  = 8'd0;
      end
    endcase
  end

  assign valid = (state_q == StRun);
  assign done  = (state_q == StDone);
  assign step  = step_q;

  // Step s, channel c sits (Steps-1-s)*CH + c bytes up from the right end of SEQ.
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [9:0] bit_off;
    logic [7:0] ch_byte;
    logic [3:0] val;
    logic       ch_dc;

    assign bit_off = 10'(LastStep - step_q) * 10'(CH * 8) + 10'(c * 8);
    assign ch_byte = SEQ[bit_off +: 8];

    seq_char_dec u_dec (
      .ch  (ch_byte),
      .val (val),
      .dc  (ch_dc)
    );

    assign dout[c*N +: N] = valid ? val[N-1:0] : '0;
    assign dc[c]          = valid & ch_dc;

    if (N < 4) begin : g_trunc
      logic unused_hi;
      assign unused_hi = ^val[3:N];
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench: stimulus pushes the expected post-edge outputs, a monitor pops and compares.
module tb_seq_gen;

  localparam logic [1023:0] SeqA = 1024'("0123");
  localparam logic [1023:0] SeqB = 1024'("1x-");
  localparam logic [1023:0] SeqC = 1024'("ABC");
  localparam logic [1023:0] SeqD = 1024'("123");
  localparam logic [1023:0] SeqE = 1024'("12345");
  localparam logic [1023:0] SeqF = 1024'("7");

  typedef struct packed {
    logic [2:0]  sel;
    logic        valid;
    logic        done;
    logic [7:0]  step;
    logic [15:0] dout;
    logic [3:0]  dc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;

  logic [7:0] dout_a; logic [1:0] dc_a; logic valid_a, done_a; logic [7:0] step_a;
  logic [1:0] dout_b; logic [0:0] dc_b; logic valid_b, done_b; logic [7:0] step_b;
  logic [3:0] dout_c; logic [0:0] dc_c; logic valid_c, done_c; logic [7:0] step_c;
  logic [3:0] dout_d; logic [0:0] dc_d; logic valid_d, done_d; logic [7:0] step_d;
  logic [3:0] dout_e; logic [0:0] dc_e; logic valid_e, done_e; logic [7:0] step_e;
  logic [3:0] dout_f; logic [0:0] dc_f; logic valid_f, done_f; logic [7:0] step_f;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks   = 0;
  int    failures = 0;

  always #5 clock = ~clock;

  seq_gen #(.SEQ(SeqA), .N(4), .CH(2), .LOOP(0)) u_a (
    .clock(clock), .reset(reset), .start(start), .stall(stall),
    .dout(dout_a), .dc(dc_a), .valid(valid_a), .done(done_a), .step(step_a));
  seq_gen #(.SEQ(SeqB), .N(2), .CH(1), .LOOP(0)) u_b (
    .clock(clock), .reset(reset), .start(start), .stall(stall),
    .dout(dout_b), .dc(dc_b), .valid(valid_b), .done(done_b), .step(step_b));
  seq_gen #(.SEQ(SeqC), .N(4), .CH(1), .LOOP(1)) u_c (
    .clock(clock), .reset(reset), .start(start), .stall(stall),
    .dout(dout_c), .dc(dc_c), .valid(valid_c), .done(done_c), .step(step_c));
  seq_gen #(.SEQ(SeqD), .N(4), .CH(1), .LOOP(0)) u_d (
    .clock(clock), .reset(reset), .start(start), .stall(stall),
    .dout(dout_d), .dc(dc_d), .valid(valid_d), .done(done_d), .step(step_d));
  seq_gen #(.SEQ(SeqE), .N(4), .CH(1), .LOOP(0)) u_e (
    .clock(clock), .reset(reset), .start(start), .stall(stall),
    .dout(dout_e), .dc(dc_e), .valid(valid_e), .done(done_e), .step(step_e));
  seq_gen #(.SEQ(SeqF), .N(4), .CH(1), .LOOP(1)) u_f (
    .clock(clock), .reset(reset), .start(start), .stall(stall),
    .dout(dout_f), .dc(dc_f), .valid(valid_f), .done(done_f), .step(step_f));

  // Drive one cycle of inputs on the falling edge and queue what the next rising edge must show.
  task automatic cyc(input int sel, input logic st, input logic sl, input logic rs,
                     input logic v, input logic d, input int s, input int o, input int c,
                     input string tag);
    exp_t e;
    @(negedge clock);
    start = st;
    stall = sl;
    reset = rs;
    e.sel   = 3'(sel);
    e.valid = v;
    e.done  = d;
    e.step  = 8'(s);
    e.dout  = 16'(o);
    e.dc    = 4'(c);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Monitor: after each rising edge, compare the addressed instance against the oldest entry.
  initial begin
    exp_t        e;
    string       t;
    logic        av, ad;
    logic [7:0]  as;
    logic [15:0] ao;
    logic [3:0]  ac;
    forever begin
      @(posedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        case (e.sel)
          3'd0: begin av = valid_a; ad = done_a; as = step_a; ao = 16'(dout_a); ac = 4'(dc_a); end
          3'd1: begin av = valid_b; ad = done_b; as = step_b; ao = 16'(dout_b); ac = 4'(dc_b); end
          3'd2: begin av = valid_c; ad = done_c; as = step_c; ao = 16'(dout_c); ac = 4'(dc_c); end
          3'd3: begin av = valid_d; ad = done_d; as = step_d; ao = 16'(dout_d); ac = 4'(dc_d); end
          3'd4: begin av = valid_e; ad = done_e; as = step_e; ao = 16'(dout_e); ac = 4'(dc_e); end
          default: begin
            av = valid_f; ad = done_f; as = step_f; ao = 16'(dout_f); ac = 4'(dc_f);
          end
        endcase
        checks++;
        if (av !== e.valid || ad !== e.done || as !== e.step || ao !== e.dout || ac !== e.dc)
        begin
          failures++;
          $display("FAIL %s: got valid=%b done=%b step=%0d dout=%h dc=%h, want valid=%b done=%b step=%0d dout=%h dc=%h",
                   t, av, ad, as, ao, ac, e.valid, e.done, e.step, e.dout, e.dc);
        end
      end
    end
  end

  initial begin
    // "0123", CH=2, N=4: steps 8'h01, 8'h23, then DONE; start held through DONE restarts.
    cyc(0, 0, 0, 1, 0, 0, 0, 'h00, 0, "a_reset");
    cyc(0, 0, 0, 0, 0, 0, 0, 'h00, 0, "a_idle");
    cyc(0, 1, 0, 0, 1, 0, 0, 'h01, 0, "a_step0");
    cyc(0, 0, 0, 0, 1, 0, 1, 'h23, 0, "a_step1");
    cyc(0, 0, 0, 0, 0, 1, 1, 'h00, 0, "a_done");
    cyc(0, 0, 0, 0, 0, 1, 1, 'h00, 0, "a_done_hold");
    cyc(0, 1, 0, 0, 1, 0, 0, 'h01, 0, "a_restart0");
    cyc(0, 1, 0, 0, 1, 0, 1, 'h23, 0, "a_start_ignored_in_run");
    cyc(0, 1, 0, 0, 0, 1, 1, 'h00, 0, "a_done_with_start");
    cyc(0, 1, 0, 0, 1, 0, 0, 'h01, 0, "a_immediate_restart");
    cyc(0, 0, 0, 0, 1, 0, 1, 'h23, 0, "a_rerun1");

    // "1x-", N=2: 1/dc0, 0/dc1, 3/dc0, DONE; stall ignored in DONE.
    cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, "b_reset");
    cyc(1, 1, 0, 0, 1, 0, 0, 1, 0, "b_char_1");
    cyc(1, 0, 0, 0, 1, 0, 1, 0, 1, "b_char_x");
    cyc(1, 0, 0, 0, 1, 0, 2, 3, 0, "b_char_dash");
    cyc(1, 0, 0, 0, 0, 1, 2, 0, 0, "b_done");
    cyc(1, 0, 1, 0, 0, 1, 2, 0, 0, "b_stall_in_done");

    // "ABC" looping: 0,1,2,0,1,2,0 and never DONE.
    cyc(2, 0, 0, 1, 0, 0, 0, 0, 0, "c_reset");
    cyc(2, 1, 0, 0, 1, 0, 0, 10, 0, "c_s0");
    cyc(2, 0, 0, 0, 1, 0, 1, 11, 0, "c_s1");
    cyc(2, 0, 0, 0, 1, 0, 2, 12, 0, "c_s2");
    cyc(2, 0, 0, 0, 1, 0, 0, 10, 0, "c_wrap0");
    cyc(2, 0, 0, 0, 1, 0, 1, 11, 0, "c_wrap1");
    cyc(2, 0, 0, 0, 1, 0, 2, 12, 0, "c_wrap2");
    cyc(2, 0, 0, 0, 1, 0, 0, 10, 0, "c_wrap0b");

    // "123" with stall held three cycles at step 1.
    cyc(3, 0, 0, 1, 0, 0, 0, 0, 0, "d_reset");
    cyc(3, 1, 0, 0, 1, 0, 0, 1, 0, "d_s0");
    cyc(3, 0, 0, 0, 1, 0, 1, 2, 0, "d_s1");
    cyc(3, 0, 1, 0, 1, 0, 1, 2, 0, "d_stall1");
    cyc(3, 0, 1, 0, 1, 0, 1, 2, 0, "d_stall2");
    cyc(3, 0, 1, 0, 1, 0, 1, 2, 0, "d_stall3");
    cyc(3, 0, 0, 0, 1, 0, 2, 3, 0, "d_s2");
    cyc(3, 0, 0, 0, 0, 1, 2, 0, 0, "d_done");

    // "12345": reset at step 2 overrides start/stall; next start begins at step 0.
    cyc(4, 0, 0, 1, 0, 0, 0, 0, 0, "e_reset");
    cyc(4, 1, 0, 0, 1, 0, 0, 1, 0, "e_s0");
    cyc(4, 0, 0, 0, 1, 0, 1, 2, 0, "e_s1");
    cyc(4, 0, 0, 0, 1, 0, 2, 3, 0, "e_s2");
    cyc(4, 1, 1, 1, 0, 0, 0, 0, 0, "e_mid_reset");
    cyc(4, 0, 0, 0, 0, 0, 0, 0, 0, "e_idle_after_reset");
    cyc(4, 1, 0, 0, 1, 0, 0, 1, 0, "e_restart_s0");
    cyc(4, 0, 0, 0, 1, 0, 1, 2, 0, "e_restart_s1");

    // "7" looping with a single step: stays at step 0 with valid high.
    cyc(5, 0, 0, 1, 0, 0, 0, 0, 0, "f_reset");
    cyc(5, 1, 0, 0, 1, 0, 0, 7, 0, "f_s0");
    cyc(5, 0, 0, 0, 1, 0, 0, 7, 0, "f_loop1");
    cyc(5, 0, 0, 0, 1, 0, 0, 7, 0, "f_loop2");
    cyc(5, 0, 1, 0, 1, 0, 0, 7, 0, "f_stall");
    cyc(5, 1, 0, 0, 1, 0, 0, 7, 0, "f_start_in_run");

    // Let the monitor drain, bounded.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
    #5;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
